// File: rtl/aes_pkg.sv
// AES field constants and byte-level helpers shared by the S-box lanes.
// GF(2^8) arithmetic uses the AES polynomial x^8+x^4+x^3+x+1.
package aes_pkg;

  localparam logic [7:0] AES_POLY     = 8'h1B;
  localparam logic [7:0] AES_AFFINE_C = 8'h63;
  localparam logic [7:0] INV_EXP      = 8'hFE;

  function automatic logic [7:0] rotl8(
    input logic [7:0] x,
    input int         n
  );
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] aff_fwd(input logic [7:0] x);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2)
             ^ rotl8(x, 3) ^ rotl8(x, 4);
  endfunction

  function automatic logic [7:0] aff_inv(input logic [7:0] x);
    return rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] s;
    p = '0;
    s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ s;
      s = {s[6:0], 1'b0} ^ (s[7] ? AES_POLY : 8'h00);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8), and maps 0 to 0 without a special case
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (INV_EXP[i]) r = gf_mul(r, x);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One byte of S-box: a shared field inverter wrapped by the
// forward or inverse affine map selected per beat.
module aes_sbox_lane
  import aes_pkg::*;
#(
  parameter bit SUPPORT_INV = 1'b1
) (
  input  logic [7:0] x,
  input  logic       inv,
  output logic [7:0] y
);

  logic [7:0] pre;
  logic [7:0] t;

  assign t = gf_inv(pre);

  if (SUPPORT_INV) begin : g_inv
    assign pre = inv ? aff_inv(x ^ AES_AFFINE_C) : x;
    assign y   = inv ? t : (aff_fwd(t) ^ AES_AFFINE_C);
  end else begin : g_fwd
    logic unused_inv;
    assign unused_inv = inv;
    assign pre        = x;
    assign y          = aff_fwd(t) ^ AES_AFFINE_C;
  end

endmodule

// File: rtl/aes_sbox_pipe.sv
// Multi-lane AES S-box engine behind an elastic valid/ready pipeline.
// Substitution happens before stage 0; later stages only carry results.
module aes_sbox_pipe
  import aes_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int PIPE_STAGES = 2,
  parameter bit SUPPORT_INV = 1'b1,
  parameter int TAG_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_inv,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int W = 8 * LANES;

  logic [W-1:0] sub;

  logic [PIPE_STAGES-1:0]            vq;
  logic [PIPE_STAGES-1:0]            adv;
  logic [PIPE_STAGES-1:0][W-1:0]     dq;
  logic [PIPE_STAGES-1:0][TAG_W-1:0] tq;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    aes_sbox_lane #(
      .SUPPORT_INV(SUPPORT_INV)
    ) u_lane (
      .x  (in_data[8*i +: 8]),
      .inv(in_inv),
      .y  (sub[8*i +: 8])
    );
  end

  // Ready ripples back from the sink through any empty stage
  always_comb begin
    logic down;
    adv  = '0;
    down = out_ready;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      adv[k] = ~vq[k] | down;
      down   = adv[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vq[0] <= 1'b0;
      dq[0] <= '0;
      tq[0] <= '0;
    end else if (adv[0]) begin
      vq[0] <= in_valid;
      dq[0] <= sub;
      tq[0] <= in_tag;
    end
  end

  for (genvar k = 1; k < PIPE_STAGES; k++) begin : g_stage
    always_ff @(posedge clk) begin
      if (rst) begin
        vq[k] <= 1'b0;
        dq[k] <= '0;
        tq[k] <= '0;
      end else if (adv[k]) begin
        vq[k] <= vq[k-1];
        dq[k] <= dq[k-1];
        tq[k] <= tq[k-1];
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = vq[PIPE_STAGES-1];
  assign out_data  = dq[PIPE_STAGES-1];
  assign out_tag   = tq[PIPE_STAGES-1];

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// Randomized scoreboard bench for aes_sbox_pipe against S-box
// tables derived from first principles (search inverse + bitwise affine).
module tb_aes_sbox_pipe;

  localparam int LANES = 4;
  localparam int PS    = 2;
  localparam int TW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_inv;
  logic [TW-1:0] in_tag;
  logic          out_ready;
  logic          in_ready, out_valid;
  logic [31:0]   out_data;
  logic [TW-1:0] out_tag;
  logic          in_ready0, out_valid0;
  logic [31:0]   out_data0;
  logic [TW-1:0] out_tag0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_in     = 0;

  logic [7:0]  sbox_f [256];
  logic [7:0]  sbox_i [256];
  logic [35:0] sb [$];

  always #5 clk = ~clk;

  aes_sbox_pipe #(
    .LANES(LANES), .PIPE_STAGES(PS), .SUPPORT_INV(1'b1), .TAG_W(TW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_inv(in_inv), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  aes_sbox_pipe #(
    .LANES(LANES), .PIPE_STAGES(PS), .SUPPORT_INV(1'b0), .TAG_W(TW)
  ) dut_fwd (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_inv(in_inv), .in_tag(in_tag),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_tag(out_tag0)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int cl_mul(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++)
      if ((b >> i) & 1) p = p ^ (a << i);
    for (int bit_i = 14; bit_i >= 8; bit_i--)
      if ((p >> bit_i) & 1) p = p ^ (32'h11B << (bit_i - 8));
    return p & 8'hFF;
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      int inv_x;
      logic [7:0] a, b;
      logic [7:0] c;
      inv_x = 0;
      for (int y = 1; y < 256; y++)
        if (cl_mul(x, y) == 1) inv_x = y;
      a = inv_x[7:0];
      c = 8'h63;
      for (int i = 0; i < 8; i++)
        b[i] = a[i] ^ a[(i+4)%8] ^ a[(i+5)%8]
             ^ a[(i+6)%8] ^ a[(i+7)%8] ^ c[i];
      sbox_f[x] = b;
    end
    for (int x = 0; x < 256; x++) sbox_i[sbox_f[x]] = x[7:0];
  endtask

  function automatic logic [31:0] model(
    input logic [31:0] d,
    input logic        inv
  );
    logic [31:0] r;
    for (int i = 0; i < LANES; i++)
      r[8*i +: 8] = inv ? sbox_i[d[8*i +: 8]] : sbox_f[d[8*i +: 8]];
    return r;
  endfunction

  task automatic cyc();
    logic [35:0] e;
    #1;
    if (!rst) begin
      if (in_valid && in_ready) begin
        sb.push_back({in_tag, model(in_data, in_inv)});
        n_in++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out", 64'(out_data), 64'hDEAD_0000_0000);
        end else begin
          e = sb.pop_front();
          check("out_data", 64'(out_data), 64'(e[31:0]));
          check("out_tag", 64'(out_tag), 64'(e[35:32]));
        end
      end
    end
    @(posedge clk);
    if (rst) sb.delete();
    @(negedge clk);
  endtask

  task automatic send_one(
    input logic [31:0]   d,
    input logic          inv,
    input logic [TW-1:0] tag,
    input logic [31:0]   exp1,
    input logic [31:0]   exp0
  );
    int lat;
    in_valid  = 1'b1;
    in_data   = d;
    in_inv    = inv;
    in_tag    = tag;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      cyc();
      lat++;
    end
    check("latency", 64'(lat), 64'(PS));
    check("dir_data", 64'(out_data), 64'(exp1));
    check("dir_tag", 64'(out_tag), 64'(tag));
    check("fwd_only_valid", 64'(out_valid0), 64'd1);
    check("fwd_only_data", 64'(out_data0), 64'(exp0));
    check("fwd_only_tag", 64'(out_tag0), 64'(tag));
    cyc();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < PS + 4; i++) cyc();
    check("drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int n0;
    int cycles;
    logic [31:0] hold;
    logic        held;

    build_tables();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hA5A5_A5A5;
    in_inv    = 1'b0;
    in_tag    = 4'hF;
    out_ready = 1'b0;
    @(negedge clk);
    repeat (3) cyc();
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    send_one(32'hFF53_0100, 1'b0, 4'h5, 32'h16ED_7C63, 32'h16ED_7C63);
    send_one(32'h16ED_7C63, 1'b1, 4'hA, 32'hFF53_0100, 32'h4755_10FB);

    // every byte value through every lane, mode flipping each beat
    out_ready = 1'b1;
    n0 = n_in;
    for (int v = 0; v < 256; v++) begin
      in_valid = 1'b1;
      for (int i = 0; i < LANES; i++) in_data[8*i +: 8] = 8'(v + 64 * i);
      in_inv = v[0];
      in_tag = v[3:0];
      cyc();
    end
    check("full_rate", 64'(n_in - n0), 64'd256);
    drain();

    // stall the sink while the source keeps pushing
    out_ready = 1'b0;
    n0   = n_in;
    held = 1'b0;
    hold = '0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_inv   = 1'($urandom);
      in_tag   = 4'($urandom);
      cyc();
      if (out_valid) begin
        if (!held) begin
          hold = out_data;
          held = 1'b1;
        end else begin
          check("stall_hold", 64'(out_data), 64'(hold));
        end
      end
    end
    check("stall_accepted", 64'(n_in - n0), 64'(PS));
    #1;
    check("stall_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_data = $urandom;
      in_tag  = 4'($urandom);
      cyc();
    end
    drain();

    // random valid/ready on both sides
    n0     = n_in;
    cycles = 0;
    while ((n_in - n0) < 10000 && cycles < 60000) begin
      in_valid  = 1'($urandom);
      in_data   = $urandom;
      in_inv    = 1'($urandom);
      in_tag    = 4'($urandom);
      out_ready = 1'($urandom);
      cyc();
      cycles++;
    end
    check("random_beats", 64'(n_in - n0), 64'd10000);
    drain();

    // reset with two beats in flight
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_tag   = 4'($urandom);
      cyc();
    end
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    cyc();
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) cyc();
    send_one(32'h0001_53FF, 1'b0, 4'h3, 32'h637C_ED16, 32'h637C_ED16);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
